// File: rtl/psx_pad_responder.sv
// PSX digital-pad device-side responder: shifts the 5-byte poll reply out on dat,
// captures host command bytes, and pulses ack_n between bytes.
//
// state    | meaning
// IDLE     | waiting for att_n falling edge
// SHIFT    | exchanging bits of the current byte on psx_clk rising edges
// ACK_WAIT | delay between byte completion and ack_n assertion
// ACK_LOW  | ack_n held low
// DONE     | transaction over; ignore psx_clk until att_n rises
module psx_pad_responder #(
    parameter int         ACK_DELAY = 2,
    parameter int         ACK_WIDTH = 2,
    parameter int         NUM_BYTES = 5,
    parameter logic [7:0] PAD_ID    = 8'h41
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        att_n,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    output logic        dat,
    output logic        ack_n,
    output logic [7:0]  rx_cmd,
    output logic        rx_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_ACK_WAIT,
        S_ACK_LOW,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES - 1);
    localparam logic [3:0] DLY_LOAD  = 4'(ACK_DELAY - 1);
    localparam logic [3:0] WID_LOAD  = 4'(ACK_WIDTH - 1);

    state_t      state_q, state_d;
    logic        att_prev_q, att_prev_d;
    logic        clk_prev_q, clk_prev_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [15:0] btn_q, btn_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dat_q, dat_d;
    logic        ack_n_q, ack_n_d;
    logic [7:0]  rx_cmd_q, rx_cmd_d;
    logic        rx_valid_q, rx_valid_d;

    logic        psx_rise, att_fall, byte_last;
    logic [2:0]  nxt_bit;
    logic [7:0]  done_byte, first_resp, cur_resp, next_resp;

    function automatic logic [7:0] resp_byte(input logic [3:0] idx, input logic [15:0] btn);
        case (idx)
            4'd0:    resp_byte = 8'hFF;
            4'd1:    resp_byte = PAD_ID;
            4'd2:    resp_byte = 8'h5A;
            4'd3:    resp_byte = btn[7:0];
            4'd4:    resp_byte = btn[15:8];
            default: resp_byte = 8'hFF;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        att_prev_d = att_n;
        clk_prev_d = psx_clk;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        btn_d      = btn_q;
        cnt_d      = cnt_q;
        dat_d      = dat_q;
        ack_n_d    = ack_n_q;
        rx_cmd_d   = rx_cmd_q;
        rx_valid_d = 1'b0;

        psx_rise   = !clk_prev_q && psx_clk;
        att_fall   = att_prev_q && !att_n;
        nxt_bit    = bit_idx_q + 3'd1;
        done_byte  = {cmd, shreg_q};
        first_resp = resp_byte(4'd0, buttons);
        cur_resp   = resp_byte(byte_idx_q, btn_q);
        next_resp  = resp_byte(byte_idx_q + 4'd1, btn_q);
        byte_last  = (byte_idx_q == LAST_BYTE)
                  || (byte_idx_q == 4'd0 && done_byte != 8'h01)
                  || (byte_idx_q == 4'd1 && done_byte != 8'h42);

        case (state_q)
            S_IDLE: begin
                dat_d   = 1'b1;
                ack_n_d = 1'b1;
                if (att_fall) begin
                    state_d    = S_SHIFT;
                    byte_idx_d = 4'd0;
                    bit_idx_d  = 3'd0;
                    btn_d      = buttons;
                    dat_d      = first_resp[0];
                end
            end
            S_SHIFT: begin
                if (psx_rise) begin
                    if (bit_idx_q == 3'd7) begin
                        rx_cmd_d   = done_byte;
                        rx_valid_d = 1'b1;
                        dat_d      = 1'b1;
                        bit_idx_d  = 3'd0;
                        if (byte_last) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ACK_WAIT;
                            cnt_d   = DLY_LOAD;
                        end
                    end else begin
                        shreg_d[bit_idx_q] = cmd;
                        bit_idx_d          = nxt_bit;
                        dat_d              = cur_resp[nxt_bit];
                    end
                end
            end
            S_ACK_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK_LOW;
                    ack_n_d = 1'b0;
                    cnt_d   = WID_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK_LOW: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_SHIFT;
                    ack_n_d    = 1'b1;
                    byte_idx_d = byte_idx_q + 4'd1;
                    dat_d      = next_resp[0];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                dat_d   = 1'b1;
                ack_n_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Host releasing attention wins over everything except the rx report.
        if (state_q != S_IDLE && att_n) begin
            state_d    = S_IDLE;
            dat_d      = 1'b1;
            ack_n_d    = 1'b1;
            byte_idx_d = 4'd0;
            bit_idx_d  = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            att_prev_q <= 1'b0;
            clk_prev_q <= 1'b1;
            byte_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 7'd0;
            btn_q      <= 16'hFFFF;
            cnt_q      <= 4'd0;
            dat_q      <= 1'b1;
            ack_n_q    <= 1'b1;
            rx_cmd_q   <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            att_prev_q <= att_prev_d;
            clk_prev_q <= clk_prev_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            btn_q      <= btn_d;
            cnt_q      <= cnt_d;
            dat_q      <= dat_d;
            ack_n_q    <= ack_n_d;
            rx_cmd_q   <= rx_cmd_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign dat      = dat_q;
    assign ack_n    = ack_n_q;
    assign rx_cmd   = rx_cmd_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_psx_pad_responder.sv
// Self-checking bench for psx_pad_responder: directed vector table, hand-written
// corner sequences, and randomized transactions against a rule-level pad model.
module tb_psx_pad_responder;

    localparam int         D   = 2;
    localparam int         W   = 2;
    localparam int         NB  = 5;
    localparam logic [7:0] PID = 8'h41;

    logic        clk = 1'b0;
    logic        rst, att_n, psx_clk, cmd;
    logic [15:0] buttons;
    logic        dat, ack_n, rx_valid, busy;
    logic [7:0]  rx_cmd;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    psx_pad_responder #(
        .ACK_DELAY(D), .ACK_WIDTH(W), .NUM_BYTES(NB), .PAD_ID(PID)
    ) dut (
        .clk(clk), .rst(rst), .att_n(att_n), .psx_clk(psx_clk), .cmd(cmd),
        .buttons(buttons), .dat(dat), .ack_n(ack_n), .rx_cmd(rx_cmd),
        .rx_valid(rx_valid), .busy(busy)
    );

    typedef struct {
        logic [47:0] cmds;
        int          nsend;
        logic [15:0] btn;
        logic [15:0] btn_mid;
        bit          tog;
        logic [47:0] exp_dat;
        logic [47:0] exp_rx;
        int          exp_nrx;
        int          exp_nack;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] c, output logic [7:0] d,
                             output logic rxv, output logic [7:0] rxc);
        for (int i = 0; i < 8; i++) begin
            psx_clk = 1'b0;
            cmd     = c[i];
            cyc();
            d[i]    = dat;
            psx_clk = 1'b1;
            cyc();
        end
        rxv = rx_valid;
        rxc = rx_cmd;
    endtask

    // Inter-byte gap; optionally wiggles psx_clk while the pad should be ignoring it.
    task automatic ack_window(input bit tog, output int start, output int low, output int extra_rx);
        start    = -1;
        low      = 0;
        extra_rx = 0;
        for (int k = 0; k < 12; k++) begin
            psx_clk = (tog && k < D + W - 1) ? 1'(k % 2) : 1'b1;
            cyc();
            if (ack_n == 1'b0) begin
                if (start < 0) start = k + 1;
                low++;
            end
            if (rx_valid) extra_rx++;
        end
        psx_clk = 1'b1;
    endtask

    task automatic run_xact(input logic [47:0] cmds, input int nsend, input logic [15:0] btn,
                            input logic [15:0] btn_mid, input bit tog,
                            output logic [47:0] dats, output logic [47:0] rxs,
                            output int n_rx, output int n_ack);
        logic [7:0] d, rc;
        logic       rv;
        int         st, lo, ex;
        dats  = '0;
        rxs   = '0;
        n_rx  = 0;
        n_ack = 0;
        att_n = 1'b1;
        psx_clk = 1'b1;
        buttons = btn;
        cyc();
        cyc();
        att_n = 1'b0;
        cyc();
        for (int b = 0; b < nsend; b++) begin
            if (b == 2) buttons = btn_mid;
            send_byte(cmds[b*8 +: 8], d, rv, rc);
            dats[b*8 +: 8] = d;
            if (rv) begin
                rxs[b*8 +: 8] = rc;
                n_rx++;
            end
            ack_window(tog, st, lo, ex);
            n_rx += ex;
            if (st >= 0) begin
                n_ack++;
                check("ack_delay", st, D);
                check("ack_width", lo, W);
            end
        end
        att_n = 1'b1;
        cyc();
        check("end_busy", busy, 0);
        check("end_dat", dat, 1);
    endtask

    function automatic logic [7:0] model_resp(input int i, input logic [15:0] btn);
        if (i == 0)      return 8'hFF;
        else if (i == 1) return PID;
        else if (i == 2) return 8'h5A;
        else if (i == 3) return btn[7:0];
        else if (i == 4) return btn[15:8];
        else             return 8'hFF;
    endfunction

    // Pad behaviour from the protocol rules: find the byte that ends the exchange.
    function automatic void model(input logic [47:0] cmds, input int nsend, input logic [15:0] btn,
                                  output logic [47:0] dats, output logic [47:0] rxs,
                                  output int nrx, output int nack);
        int stop = NB - 1;
        for (int i = NB - 1; i >= 0; i--) begin
            if ((i == 0 && cmds[7:0] != 8'h01) || (i == 1 && cmds[15:8] != 8'h42)) stop = i;
        end
        dats = '0;
        rxs  = '0;
        for (int i = 0; i < nsend; i++) begin
            dats[i*8 +: 8] = (i <= stop) ? model_resp(i, btn) : 8'hFF;
            if (i <= stop) rxs[i*8 +: 8] = cmds[i*8 +: 8];
        end
        nrx  = (nsend < stop + 1) ? nsend : stop + 1;
        nack = (nsend < stop) ? nsend : stop;
    endfunction

    task automatic compare_xact(input string tag, input int nsend,
                                input logic [47:0] gd, input logic [47:0] ed,
                                input logic [47:0] gr, input logic [47:0] er,
                                input int gnrx, input int enrx, input int gnack, input int enack);
        for (int b = 0; b < nsend; b++)
            check($sformatf("%s_dat_b%0d", tag, b), gd[b*8 +: 8], ed[b*8 +: 8]);
        check($sformatf("%s_rx_bytes", tag), gr, er);
        check($sformatf("%s_rx_count", tag), gnrx, enrx);
        check($sformatf("%s_ack_count", tag), gnack, enack);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [6];
        logic [47:0] gd, gr, ed, er, rc48;
        int          gnrx, gnack, enrx, enack, st, lo, ex, cnt;
        logic [7:0]  d, rc, c;
        logic [15:0] rb, rbm;
        logic        rv, seen;
        int          ns;
        bit          tg;

        vecs[0] = '{48'h00_00_00_00_42_01, 5, 16'hFFFE, 16'hFFFE, 1'b0,
                    48'h00_FF_FE_5A_41_FF, 48'h00_00_00_00_42_01, 5, 4};
        vecs[1] = '{48'h00_00_00_00_42_03, 2, 16'hFFFF, 16'hFFFF, 1'b0,
                    48'h00_00_00_00_FF_FF, 48'h00_00_00_00_00_03, 1, 0};
        vecs[2] = '{48'h00_00_00_00_43_01, 3, 16'h0000, 16'h0000, 1'b0,
                    48'h00_00_00_FF_41_FF, 48'h00_00_00_00_43_01, 2, 1};
        vecs[3] = '{48'h00_00_00_00_42_01, 5, 16'hFFFF, 16'h0000, 1'b0,
                    48'h00_FF_FF_5A_41_FF, 48'h00_00_00_00_42_01, 5, 4};
        vecs[4] = '{48'h00_5A_A5_3C_42_01, 5, 16'h1234, 16'h1234, 1'b1,
                    48'h00_12_34_5A_41_FF, 48'h00_5A_A5_3C_42_01, 5, 4};
        vecs[5] = '{48'h77_00_00_00_42_01, 6, 16'hA55A, 16'hA55A, 1'b0,
                    48'hFF_A5_5A_5A_41_FF, 48'h00_00_00_00_42_01, 5, 4};

        rst = 1'b1;
        att_n = 1'b1;
        psx_clk = 1'b1;
        cmd = 1'b0;
        buttons = 16'hFFFF;
        cyc();
        cyc();
        cyc();
        check("rst_dat", dat, 1);
        check("rst_ack_n", ack_n, 1);
        check("rst_rx_cmd", rx_cmd, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        cyc();

        for (int v = 0; v < 6; v++) begin
            run_xact(vecs[v].cmds, vecs[v].nsend, vecs[v].btn, vecs[v].btn_mid, vecs[v].tog,
                     gd, gr, gnrx, gnack);
            compare_xact($sformatf("vec%0d", v), vecs[v].nsend, gd, vecs[v].exp_dat,
                         gr, vecs[v].exp_rx, gnrx, vecs[v].exp_nrx, gnack, vecs[v].exp_nack);
        end

        // Abort after 4 rising edges of byte 2.
        att_n = 1'b0;
        cyc();
        send_byte(8'h01, d, rv, rc);
        ack_window(1'b0, st, lo, ex);
        send_byte(8'h42, d, rv, rc);
        ack_window(1'b0, st, lo, ex);
        for (int i = 0; i < 4; i++) begin
            psx_clk = 1'b0;
            cmd = 1'b1;
            cyc();
            psx_clk = 1'b1;
            cyc();
        end
        att_n = 1'b1;
        cyc();
        check("abort_busy", busy, 0);
        check("abort_dat", dat, 1);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_rx_cmd", rx_cmd, 8'h42);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (rx_valid || !ack_n || busy) cnt++;
        end
        check("abort_quiet", cnt, 0);

        // Reset while ack_n is low.
        att_n = 1'b0;
        cyc();
        send_byte(8'h01, d, rv, rc);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            cyc();
            if (ack_n == 1'b0) seen = 1'b1;
        end
        check("rstack_seen_low", seen, 1);
        rst = 1'b1;
        cyc();
        check("rstack_ack_n", ack_n, 1);
        check("rstack_busy", busy, 0);
        check("rstack_rx_cmd", rx_cmd, 8'h00);
        rst = 1'b0;
        cyc();
        cyc();
        cyc();
        check("rstack_no_restart", busy, 0);
        att_n = 1'b1;
        cyc();

        // att_n released in the same cycle as the 8th rising edge.
        c = 8'h01;
        att_n = 1'b0;
        cyc();
        for (int i = 0; i < 7; i++) begin
            psx_clk = 1'b0;
            cmd = c[i];
            cyc();
            psx_clk = 1'b1;
            cyc();
        end
        psx_clk = 1'b0;
        cmd = c[7];
        cyc();
        psx_clk = 1'b1;
        att_n = 1'b1;
        cyc();
        check("coinc_rx_valid", rx_valid, 1);
        check("coinc_rx_cmd", rx_cmd, 8'h01);
        check("coinc_busy", busy, 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (!ack_n) cnt++;
        end
        check("coinc_no_ack", cnt, 0);

        for (int r = 0; r < 20; r++) begin
            rc48 = {$urandom, $urandom};
            if ($urandom_range(0, 5) != 0) rc48[7:0] = 8'h01;
            if ($urandom_range(0, 5) != 0) rc48[15:8] = 8'h42;
            ns  = $urandom_range(1, 6);
            rb  = 16'($urandom);
            rbm = 16'($urandom);
            tg  = 1'($urandom_range(0, 1));
            model(rc48, ns, rb, ed, er, enrx, enack);
            run_xact(rc48, ns, rb, rbm, tg, gd, gr, gnrx, gnack);
            compare_xact($sformatf("rnd%0d", r), ns, gd, ed, gr, er, gnrx, enrx, gnack, enack);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
